// File: rtl/mic_window_sequencer.sv
// Ping-pong windowing controller: packs a sample stream into two SAMPLES-word banks,
// presents full windows in fill order through a registered random-access read port.
module mic_window_sequencer #(
    parameter  int unsigned SAMPLES = 16,
    parameter  int unsigned WIDTH   = 32,
    parameter  int unsigned CNT_W   = 16,
    localparam int unsigned AW      = $clog2(SAMPLES)
) (
    input  logic             adc_clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             win_valid,
    output logic             win_bank,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             win_release,
    output logic             overrun,
    output logic [CNT_W-1:0] overrun_count,
    input  logic             clear_overrun
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        WAIT_FREE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               wr_bank_q, wr_bank_d;
    logic [AW-1:0]      wr_idx_q, wr_idx_d;
    logic [1:0]         bank_full_q, bank_full_d;
    logic               rd_bank_q, rd_bank_d;
    logic               win_valid_q, win_valid_d;
    logic [WIDTH-1:0]   rd_data_q;
    logic               overrun_q, overrun_d;
    logic [CNT_W-1:0]   overrun_count_q, overrun_count_d;

    logic [WIDTH-1:0]   mem [2*SAMPLES];

    logic               rel_c;
    logic [1:0]         bf_rel_c;
    logic               wr_en_c;
    logic               last_c;
    logic               drop_c;

    // Release is applied before completion so a same-cycle release can free the next target bank.
    always_comb begin
        rel_c    = win_release && bank_full_q[rd_bank_q];
        bf_rel_c = bank_full_q;
        if (rel_c) begin
            bf_rel_c[rd_bank_q] = 1'b0;
        end
        wr_en_c = (state_q == FILL) && enable && sample_valid && !bank_full_q[wr_bank_q];
        last_c  = wr_en_c && (wr_idx_q == AW'(SAMPLES - 1));
        drop_c  = enable && sample_valid &&
                  ((state_q == WAIT_FREE) || ((state_q == FILL) && bank_full_q[wr_bank_q]));
    end

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                state_d = FILL;
            end
            FILL: begin
                if (last_c && bf_rel_c[~wr_bank_q]) begin
                    state_d = WAIT_FREE;
                end else if (!last_c && bf_rel_c[wr_bank_q]) begin
                    state_d = WAIT_FREE;
                end
            end
            WAIT_FREE: begin
                if (!bf_rel_c[wr_bank_q]) begin
                    state_d = FILL;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        wr_bank_d       = wr_bank_q;
        wr_idx_d        = wr_idx_q;
        bank_full_d     = bf_rel_c;
        rd_bank_d       = rel_c ? ~rd_bank_q : rd_bank_q;
        overrun_d       = overrun_q;
        overrun_count_d = overrun_count_q;

        if (!enable || (state_q == IDLE)) begin
            wr_idx_d = '0;
        end else if (last_c) begin
            wr_idx_d                = '0;
            wr_bank_d               = ~wr_bank_q;
            bank_full_d[wr_bank_q]  = 1'b1;
        end else if (wr_en_c) begin
            wr_idx_d = wr_idx_q + AW'(1);
        end

        win_valid_d = bank_full_d[rd_bank_d];

        if (clear_overrun) begin
            overrun_d       = 1'b0;
            overrun_count_d = '0;
        end else if (drop_c) begin
            overrun_d = 1'b1;
            if (overrun_count_q != '1) begin
                overrun_count_d = overrun_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank_q       <= 1'b0;
            wr_idx_q        <= '0;
            bank_full_q     <= 2'b00;
            rd_bank_q       <= 1'b0;
            win_valid_q     <= 1'b0;
            rd_data_q       <= '0;
            overrun_q       <= 1'b0;
            overrun_count_q <= '0;
        end else begin
            wr_bank_q       <= wr_bank_d;
            wr_idx_q        <= wr_idx_d;
            bank_full_q     <= bank_full_d;
            rd_bank_q       <= rd_bank_d;
            win_valid_q     <= win_valid_d;
            rd_data_q       <= mem[{rd_bank_q, rd_addr}];
            overrun_q       <= overrun_d;
            overrun_count_q <= overrun_count_d;
        end
    end

    // Sample storage is not reset; bank_full gates every consumer-visible use.
    always_ff @(posedge adc_clk) begin
        if (wr_en_c) begin
            mem[{wr_bank_q, wr_idx_q}] <= sample_in;
        end
    end

    assign win_valid     = win_valid_q;
    assign win_bank      = rd_bank_q;
    assign rd_data       = rd_data_q;
    assign overrun       = overrun_q;
    assign overrun_count = overrun_count_q;

endmodule

// File: tb/tb_mic_window_sequencer.sv
// Directed bench for mic_window_sequencer: fill, overrun, simultaneous release,
// disable mid-window, gapped input and asynchronous reset.
module tb_mic_window_sequencer;

    localparam int unsigned SAMPLES = 16;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned AW      = $clog2(SAMPLES);

    logic             adc_clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic [WIDTH-1:0] sample_in;
    logic             sample_valid;
    logic             win_valid;
    logic             win_bank;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             win_release;
    logic             overrun;
    logic [CNT_W-1:0] overrun_count;
    logic             clear_overrun;

    int checks   = 0;
    int failures = 0;

    mic_window_sequencer #(.SAMPLES(SAMPLES), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .adc_clk       (adc_clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .win_valid     (win_valid),
        .win_bank      (win_bank),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .win_release   (win_release),
        .overrun       (overrun),
        .overrun_count (overrun_count),
        .clear_overrun (clear_overrun)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic send(input int unsigned v);
        sample_in    = WIDTH'(v);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic rd(input string tag, input int unsigned addr, input int unsigned exp);
        rd_addr = AW'(addr);
        tick();
        chk(tag, 64'(rd_data), 64'(exp));
    endtask

    task automatic release_win();
        win_release = 1'b1;
        tick();
        win_release = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        enable        = 1'b0;
        sample_in     = '0;
        sample_valid  = 1'b0;
        rd_addr       = '0;
        win_release   = 1'b0;
        clear_overrun = 1'b0;
        repeat (2) tick();
        chk("rst_win_valid", 64'(win_valid), 64'd0);
        chk("rst_win_bank", 64'(win_bank), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_count", 64'(overrun_count), 64'd0);
        reset_n = 1'b1;
        tick();

        // 1: first window into bank0
        enable = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) send(i);
        chk("t1_valid_before_last", 64'(win_valid), 64'd0);
        send(15);
        chk("t1_win_valid", 64'(win_valid), 64'd1);
        chk("t1_win_bank", 64'(win_bank), 64'd0);
        for (int k = 0; k < 16; k++) rd("t1_rd", k, k);

        // 2: bank1 fills, then 16 drops
        for (int i = 0; i < 16; i++) send(200 + i);
        chk("t2_no_overrun_yet", 64'(overrun), 64'd0);
        for (int i = 0; i < 16; i++) send(900 + i);
        chk("t2_overrun", 64'(overrun), 64'd1);
        chk("t2_count", 64'(overrun_count), 64'd16);
        chk("t2_still_bank0", 64'(win_bank), 64'd0);
        rd("t2_bank0_intact", 5, 5);
        release_win();
        chk("t2_rel_bank", 64'(win_bank), 64'd1);
        chk("t2_rel_valid", 64'(win_valid), 64'd1);
        rd("t2_bank1_rd3", 3, 203);
        rd("t2_bank1_rd15", 15, 215);
        for (int i = 0; i < 16; i++) send(300 + i);
        chk("t2_count_held", 64'(overrun_count), 64'd16);

        // 3: release coincides with last sample of bank1
        release_win();
        chk("t3_bank0_shown", 64'(win_bank), 64'd0);
        rd("t3_bank0_rd2", 2, 302);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        chk("t3_clear_overrun", 64'(overrun), 64'd0);
        chk("t3_clear_count", 64'(overrun_count), 64'd0);
        for (int i = 0; i < 15; i++) send(400 + i);
        win_release = 1'b1;
        send(415);
        win_release = 1'b0;
        chk("t3_win_bank", 64'(win_bank), 64'd1);
        chk("t3_win_valid", 64'(win_valid), 64'd1);
        send(500);
        chk("t3_overrun", 64'(overrun), 64'd0);
        rd("t3_rd0", 0, 400);
        rd("t3_rd15", 15, 415);

        // 4: disable mid-window, window restarts at idx0
        for (int i = 1; i < 7; i++) send(500 + i);
        release_win();
        chk("t4_none_valid", 64'(win_valid), 64'd0);
        enable = 1'b0;
        repeat (2) tick();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) send(100 + i);
        chk("t4_win_valid", 64'(win_valid), 64'd1);
        chk("t4_win_bank", 64'(win_bank), 64'd0);
        rd("t4_rd0", 0, 100);
        rd("t4_rd6", 6, 106);
        rd("t4_rd7", 7, 107);
        rd("t4_rd15", 15, 115);

        // 5: gapped input into bank1
        release_win();
        for (int i = 0; i < 15; i++) begin
            send(600 + i);
            repeat (2) tick();
        end
        chk("t5_valid_before_last", 64'(win_valid), 64'd0);
        send(615);
        chk("t5_win_valid", 64'(win_valid), 64'd1);
        chk("t5_win_bank", 64'(win_bank), 64'd1);
        rd("t5_rd0", 0, 600);
        rd("t5_rd9", 9, 609);
        rd("t5_rd15", 15, 615);

        // 6: build some overrun, start a fill, then reset asynchronously
        for (int i = 0; i < 16; i++) send(700 + i);
        send(1);
        send(2);
        chk("t6_count", 64'(overrun_count), 64'd2);
        release_win();
        chk("t6_bank0_shown", 64'(win_bank), 64'd0);
        for (int i = 0; i < 5; i++) send(50 + i);
        rd("t6_rd3", 3, 703);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_valid", 64'(win_valid), 64'd0);
        chk("t6_async_overrun", 64'(overrun), 64'd0);
        chk("t6_async_count", 64'(overrun_count), 64'd0);
        chk("t6_async_rd_data", 64'(rd_data), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) send(800 + i);
        chk("t6_resume_valid", 64'(win_valid), 64'd1);
        chk("t6_resume_bank", 64'(win_bank), 64'd0);
        rd("t6_resume_rd0", 0, 800);
        rd("t6_resume_rd15", 15, 815);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
